// File: rtl/id_issue_stage.sv
// id_issue_stage
//   Decode/issue stage in front of the 16x16 register file. Holds one
//   instruction from fetch, drives the file's Rs/Rt read addresses from it,
//   checks a per-register busy scoreboard for RAW/WAW hazards, and issues
//   op/rd plus the latched operands to EX over a valid/ready handshake.
//   A held HLT_OP is consumed without issuing. The stage then waits until all
//   outstanding writes have retired and EX is empty, and after that raises a
//   sticky hlt.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_instr    fetch side ([15:12] op, [11:8] rd, [7:4] rs, [3:0] rt)
//   in_ready             stage accepts in_instr this cycle
//   flush                drop the held instruction
//   rf_rs/rf_rt          register file read addresses
//   rf_out_rs/rf_out_rt  register file read data
//   wb_we/wb_rd          writeback strobe and destination (clears busy)
//   ex_valid/ex_ready    issue handshake to EX
//   ex_op/ex_rd/ex_a/ex_b issued opcode, destination and operands
//   hlt                  halt to register file (sticky)
//   sb_err               sticky: writeback to a register that was not busy
module id_issue_stage #(
    parameter int         NREGS  = 16,
    parameter logic [3:0] HLT_OP = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic [3:0]  rf_rs,
    output logic [3:0]  rf_rt,
    input  logic [15:0] rf_out_rs,
    input  logic [15:0] rf_out_rt,
    input  logic        wb_we,
    input  logic [3:0]  wb_rd,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [3:0]  ex_op,
    output logic [3:0]  ex_rd,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic        hlt,
    output logic        sb_err
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
    } exPkt_t;

    state_t            state;
    logic              heldValid;
    logic [15:0]       heldInstr;
    logic [NREGS-1:0]  busy, busyNext;
    exPkt_t            exQ;
    logic              exValid, exValidNext;
    logic              hltQ, sbErrQ;

    logic [3:0] hOp, hRd, hRs, hRt;
    logic       isHlt, writes, reads, srcBusy, dstBusy, hazard, exFree;
    logic       issue, hltTake;

    assign hOp = heldInstr[15:12];
    assign hRd = heldInstr[11:8];
    assign hRs = heldInstr[7:4];
    assign hRt = heldInstr[3:0];

    assign isHlt  = (hOp == HLT_OP);
    assign writes = (hOp <= 4'h8) && !isHlt;
    assign reads  = !isHlt;

    // No bypass: a register being written back this cycle is still busy.
    assign srcBusy = reads && (busy[hRs] || busy[hRt]);
    assign dstBusy = writes && busy[hRd];
    assign hazard  = srcBusy || dstBusy;
    assign exFree  = !exValid || ex_ready;

    assign issue   = (state == RUN) && heldValid && !hazard && exFree && !isHlt && !flush;
    // HLT waits for EX to drain its current slot, the same as a normal issue would.
    assign hltTake = (state == RUN) && heldValid && isHlt && exFree && !flush;

    assign in_ready = (state == RUN) && !flush && (!heldValid || issue);

    assign rf_rs = heldValid ? hRs : 4'h0;
    assign rf_rt = heldValid ? hRt : 4'h0;

    // Set is applied after clear, so set wins if both hit the same register.
    always_comb begin
        busyNext = busy;
        if (wb_we) busyNext[wb_rd] = 1'b0;
        if (issue && writes) busyNext[hRd] = 1'b1;
    end

    assign exValidNext = issue || (exValid && !ex_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            heldValid <= 1'b0;
            heldInstr <= '0;
            busy      <= '0;
            exValid   <= 1'b0;
            exQ       <= '0;
            hltQ      <= 1'b0;
            sbErrQ    <= 1'b0;
        end else begin
            busy    <= busyNext;
            exValid <= exValidNext;

            if (flush)
                heldValid <= 1'b0;
            else if (in_valid && in_ready) begin
                heldValid <= 1'b1;
                heldInstr <= in_instr;
            end else if (issue || hltTake)
                heldValid <= 1'b0;

            if (issue)
                exQ <= '{op: hOp, rd: hRd, a: rf_out_rs, b: rf_out_rt};

            if (wb_we && !busy[wb_rd])
                sbErrQ <= 1'b1;

            case (state)
                RUN:    if (hltTake) state <= DRAIN;
                DRAIN:  if (busyNext == '0 && !exValidNext) begin
                            state <= HALTED;
                            hltQ  <= 1'b1;
                        end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    assign ex_valid = exValid;
    assign ex_op    = exQ.op;
    assign ex_rd    = exQ.rd;
    assign ex_a     = exQ.a;
    assign ex_b     = exQ.b;
    assign hlt      = hltQ;
    assign sb_err   = sbErrQ;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage. A small register file lives in the
// bench (reset to 16'h1000+index, written on wb_we) so the operand values
// can be predicted by hand. Inputs change 1 time unit after posedge; outputs
// are sampled at negedge.
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic [3:0]  rf_rs, rf_rt;
    logic [15:0] rf_out_rs, rf_out_rt;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wbData;
    logic        ex_valid, ex_ready;
    logic [3:0]  ex_op, ex_rd;
    logic [15:0] ex_a, ex_b;
    logic        hlt, sb_err;

    logic [15:0] rf [16];
    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    id_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .flush(flush),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_out_rs(rf_out_rs), .rf_out_rt(rf_out_rt),
        .wb_we(wb_we), .wb_rd(wb_rd),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
        .hlt(hlt), .sb_err(sb_err)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h1000 + 16'(i);
        end else if (wb_we) begin
            rf[wb_rd] <= wbData;
        end
    end

    assign rf_out_rs = rf[rf_rs];
    assign rf_out_rt = rf[rf_rt];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic samp;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wbData = '0; ex_ready = 1'b0;
        #12;
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_ex_valid", 16'(ex_valid), 16'd0);
        chk("rst_hlt",      16'(hlt),      16'd0);
        chk("rst_sb_err",   16'(sb_err),   16'd0);
        chk("rst_rf_rs",    16'(rf_rs),    16'd0);
        tick; rst_n = 1'b1;

        // Independent stream: ADD r1,r2,r3 ; ADD r4,r5,r6
        ex_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h0123;
        tick; in_instr = 16'h0456;
        samp;
        chk("ind_in_ready", 16'(in_ready), 16'd1);
        chk("ind_rf_rs",    16'(rf_rs),    16'd2);
        chk("ind_rf_rt",    16'(rf_rt),    16'd3);
        tick; in_valid = 1'b0;
        samp;
        chk("ind1_valid", 16'(ex_valid), 16'd1);
        chk("ind1_rd",    16'(ex_rd),    16'd1);
        chk("ind1_a",     ex_a,          16'h1002);
        chk("ind1_b",     ex_b,          16'h1003);
        tick; samp;
        chk("ind2_valid", 16'(ex_valid), 16'd1);
        chk("ind2_rd",    16'(ex_rd),    16'd4);
        chk("ind2_a",     ex_a,          16'h1005);
        chk("ind2_b",     ex_b,          16'h1006);
        tick; samp;
        chk("ind_drain_valid", 16'(ex_valid), 16'd0);

        // RAW: SUB r2,r1,r3 waits for r1 writeback
        in_valid = 1'b1; in_instr = 16'h1213;
        tick; in_valid = 1'b0;
        samp;
        chk("raw_stall_rdy", 16'(in_ready), 16'd0);
        chk("raw_rf_rs",     16'(rf_rs),    16'd1);
        tick; samp;
        chk("raw_stall_vld", 16'(ex_valid), 16'd0);
        tick; wb_we = 1'b1; wb_rd = 4'd1; wbData = 16'h00A5;
        samp;
        chk("raw_wb_cyc_rdy", 16'(in_ready), 16'd0);
        chk("raw_wb_cyc_vld", 16'(ex_valid), 16'd0);
        tick; wb_we = 1'b0;
        samp;
        chk("raw_post_rdy", 16'(in_ready), 16'd1);
        chk("raw_post_vld", 16'(ex_valid), 16'd0);
        tick; samp;
        chk("raw_iss_vld", 16'(ex_valid), 16'd1);
        chk("raw_iss_op",  16'(ex_op),    16'd1);
        chk("raw_iss_rd",  16'(ex_rd),    16'd2);
        chk("raw_iss_a",   ex_a,          16'h00A5);
        chk("raw_iss_b",   ex_b,          16'h1003);
        tick; wb_we = 1'b1; wb_rd = 4'd4; wbData = 16'h0044;
        tick; wb_rd = 4'd2; wbData = 16'h0022;
        tick; wb_we = 1'b0;
        samp;
        chk("raw_sb_err", 16'(sb_err), 16'd0);

        // WAW + backpressure on r7
        ex_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0700;
        tick; in_instr = 16'h2711;
        samp;
        chk("waw_in_ready", 16'(in_ready), 16'd1);
        tick; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            samp;
            chk("waw_bp_vld", 16'(ex_valid), 16'd1);
            chk("waw_bp_rd",  16'(ex_rd),    16'd7);
            chk("waw_bp_a",   ex_a,          16'h1000);
            chk("waw_bp_rdy", 16'(in_ready), 16'd0);
            tick;
        end
        ex_ready = 1'b1;
        samp;
        chk("waw_rdy_busy", 16'(in_ready), 16'd0);
        tick; wb_we = 1'b1; wb_rd = 4'd7; wbData = 16'h0077;
        samp;
        chk("waw_ex_drained", 16'(ex_valid), 16'd0);
        chk("waw_wb_cyc_rdy", 16'(in_ready), 16'd0);
        tick; wb_we = 1'b0;
        samp;
        chk("waw_post_rdy", 16'(in_ready), 16'd1);
        tick; samp;
        chk("waw2_vld", 16'(ex_valid), 16'd1);
        chk("waw2_op",  16'(ex_op),    16'd2);
        chk("waw2_rd",  16'(ex_rd),    16'd7);
        chk("waw2_a",   ex_a,          16'h00A5);
        tick; wb_we = 1'b1; wb_rd = 4'd7; wbData = 16'h0777;
        tick; wb_we = 1'b0;

        // Flush a held SW r2,r3
        in_valid = 1'b1; in_instr = 16'h9023;
        tick; flush = 1'b1; in_instr = 16'h0ABC;
        samp;
        chk("fl_in_ready", 16'(in_ready), 16'd0);
        chk("fl_rf_rs",    16'(rf_rs),    16'd2);
        tick; flush = 1'b0;
        samp;
        chk("fl_no_issue", 16'(ex_valid), 16'd0);
        chk("fl_empty_rdy", 16'(in_ready), 16'd1);
        chk("fl_empty_rs", 16'(rf_rs),    16'd0);
        tick; in_valid = 1'b0;
        samp;
        chk("fl_next_rs", 16'(rf_rs), 16'hB);
        tick; samp;
        chk("fl_next_vld", 16'(ex_valid), 16'd1);
        chk("fl_next_rd",  16'(ex_rd),    16'hA);
        chk("fl_next_a",   ex_a,          16'h100B);
        tick; wb_we = 1'b1; wb_rd = 4'hA; wbData = 16'h00AA;
        tick; wb_we = 1'b0;
        samp;
        chk("fl_sb_err", 16'(sb_err), 16'd0);

        // Writeback to an idle register
        tick; wb_we = 1'b1; wb_rd = 4'd9; wbData = 16'h0099;
        samp;
        chk("err_pre", 16'(sb_err), 16'd0);
        tick; wb_we = 1'b0;
        samp;
        chk("err_set", 16'(sb_err), 16'd1);
        tick; samp;
        chk("err_sticky", 16'(sb_err), 16'd1);

        // Halt drain: LW r5 then HLT
        tick; in_valid = 1'b1; in_instr = 16'h8501;
        tick; in_instr = 16'hF000;
        samp;
        chk("hl_in_ready", 16'(in_ready), 16'd1);
        tick; in_valid = 1'b0;
        samp;
        chk("hl_lw_vld", 16'(ex_valid), 16'd1);
        chk("hl_lw_op",  16'(ex_op),    16'd8);
        chk("hl_hlt_rdy", 16'(in_ready), 16'd0);
        tick;
        for (int i = 0; i < 4; i++) begin
            samp;
            chk("hl_drain_hlt", 16'(hlt),      16'd0);
            chk("hl_drain_rdy", 16'(in_ready), 16'd0);
            chk("hl_drain_vld", 16'(ex_valid), 16'd0);
            tick;
        end
        wb_we = 1'b1; wb_rd = 4'd5; wbData = 16'h0055;
        samp;
        chk("hl_wb_cyc_hlt", 16'(hlt), 16'd0);
        tick; wb_we = 1'b0; in_valid = 1'b1; in_instr = 16'h0123;
        samp;
        chk("hl_hlt",     16'(hlt),      16'd1);
        chk("hl_halt_rdy", 16'(in_ready), 16'd0);
        tick; samp;
        chk("hl_hlt_hold", 16'(hlt),      16'd1);
        chk("hl_halt_vld", 16'(ex_valid), 16'd0);
        chk("hl_halt_rdy2", 16'(in_ready), 16'd0);
        in_valid = 1'b0;

        // Async reset out of HALTED, between clock edges
        tick; #3 rst_n = 1'b0;
        #1;
        chk("ar1_hlt",      16'(hlt),      16'd0);
        chk("ar1_sb_err",   16'(sb_err),   16'd0);
        chk("ar1_in_ready", 16'(in_ready), 16'd1);
        tick; rst_n = 1'b1;

        // Async reset with an instruction parked in EX
        ex_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0123;
        tick; in_valid = 1'b0;
        tick; samp;
        chk("ar2_pre_vld", 16'(ex_valid), 16'd1);
        chk("ar2_pre_a",   ex_a,          16'h1002);
        #2 rst_n = 1'b0;
        #1;
        chk("ar2_vld", 16'(ex_valid), 16'd0);
        chk("ar2_rd",  16'(ex_rd),    16'd0);
        chk("ar2_a",   ex_a,          16'h0000);
        chk("ar2_b",   ex_b,          16'h0000);
        tick; rst_n = 1'b1;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue stage directly upstream of the 16x16-bit register file.
- Accepts 16-bit instructions from fetch and drives the file's Rs/Rt read addresses.
- Detects RAW/WAW hazards with a per-register busy scoreboard, latches the read operands, and issues to EX through a valid/ready handshake.
- Sequences halt: drains in-flight writes, then raises the file's hlt input.

Parameters:
- NREGS, 16, number of architectural registers; scoreboard width.
- HLT_OP, 4'hF, opcode treated as halt.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  16  [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt.
- in_ready  out  1  stage can accept in_instr this cycle.
- flush  in  1  synchronous; discards the held instruction.
- rf_rs  out  4  read address to register file port Rs.
- rf_rt  out  4  read address to register file port Rt.
- rf_out_rs  in  16  register file data for rf_rs.
- rf_out_rt  in  16  register file data for rf_rt.
- wb_we  in  1  writeback strobe (same signal as the register file we).
- wb_rd  in  4  writeback destination (register file Rd).
- ex_valid  out  1  issued instruction valid.
- ex_ready  in  1  EX accepts.
- ex_op  out  4  issued opcode.
- ex_rd  out  4  issued destination.
- ex_a  out  16  latched Rs operand.
- ex_b  out  16  latched Rt operand.
- hlt  out  1  halt to register file; level, sticky.
- sb_err  out  1  sticky: writeback to a non-busy register.

Behaviour:
- Reset (async, rst_n=0): held_valid=0, busy=0, ex_valid=0, ex_op/ex_rd/ex_a/ex_b=0, hlt=0, sb_err=0, state=RUN. in_ready=1 while in RUN with held_valid=0.
- Op classes:
  - 0x0-0x8 write rd and read rs, rt.
  - 0x9 (SW) and 0xA-0xE read rs, rt; no write.
  - HLT_OP reads nothing and writes nothing.
- Holding register: one entry. Loaded when in_valid && in_ready.
- in_ready = (state==RUN) && (!held_valid || issue).
- rf_rs/rf_rt are combinational from the held instruction's rs/rt fields (0 when empty).
- hazard = src_busy || dst_busy:
  - src_busy = reads && (busy[rs] || busy[rt]).
  - dst_busy = writes && busy[rd].
  - A register whose wb_we/wb_rd clears it in the current cycle still counts busy; the clear takes effect at the edge. No bypass.
- issue = held_valid && !hazard && (!ex_valid || ex_ready) && op!=HLT_OP && !flush. On issue:
  - ex_* are loaded with op, rd, rf_out_rs, rf_out_rt, and ex_valid=1.
  - busy[rd] is set if the op writes.
- ex_valid clears on ex_ready when no new issue occurs that cycle.
- Busy clear: when wb_we=1, busy[wb_rd] clears at the edge. If busy[wb_rd] was already 0, sb_err is set (sticky until reset).
- Set and clear of the same register in the same cycle cannot occur, because issue requires !busy[rd]. If it arises, set wins.
- flush=1: held_valid clears next edge; ex register and busy untouched; in_ready=0 that cycle. Flush of a held HLT keeps state=RUN.
- State machine:
  - RUN -> DRAIN: held HLT_OP with !flush and (!ex_valid || ex_ready). HLT is consumed; held_valid=0; nothing is issued to EX.
  - DRAIN -> HALTED: when busy==0 and ex_valid==0 (evaluated after this cycle's clears).
  - HALTED: hlt=1; in_ready=0; state held until reset.
  - In DRAIN, wb/ex handshakes continue; in_ready=0.
- Latency: an instruction accepted at edge N with no hazard appears on ex_* at edge N+1. Throughput is 1/cycle.
- Reset mid-operation: all state drops immediately; no hlt pulse.

Test Plan:
- Independent stream: ADD r1,r2,r3 then ADD r4,r5,r6 back-to-back, ex_ready=1 -> ex_valid on consecutive cycles; busy[1], busy[4] set; in_ready stays 1.
- RAW: ADD r1 issued, then SUB r2,r1,r3 held -> stalls (in_ready=0). wb_we=1, wb_rd=1 in cycle K -> SUB issues at edge K+1 with ex_a = value written (e.g. 16'h00A5).
- WAW/backpressure: two writes to r7 with ex_ready=0 for 3 cycles -> second stalls until both ex_ready and the r7 writeback occur; ex_* held stable throughout.
- Flush: flush=1 while SW r2,r3 is held -> no issue; busy unchanged; next instruction accepted one cycle later.
- Halt drain: issue LW r5, then HLT; hold wb 4 cycles -> state DRAIN, hlt=0; wb_rd=5 -> hlt=1 next edge, in_ready=0 thereafter.
- Error/reset: wb_we=1 with wb_rd=9 while idle -> sb_err=1. Assert rst_n=0 asynchronously mid-stream -> all outputs 0 without waiting for a clk edge.
